// File: rtl/inservice_resolver.sv
// In-service register and priority resolver for an 8-level interrupt controller.
// Define SPECIAL_MASK_EN to let smm hide masked in-service levels from the isr priority scan.
module inservice_resolver #(
    parameter int unsigned INTA_SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] irr,
    input  logic [7:0] imr,
    input  logic       INTA,
    input  logic       AEOI,
    input  logic       eoiValid,
    input  logic       eoiSpecific,
    input  logic       eoiRotate,
    input  logic [2:0] eoiLevel,
    input  logic       smm,
    output logic       INT,
    output logic [7:0] isr,
    output logic [2:0] highestPriority,
    output logic       currentPulse,
    output logic       spurious
);

    if (INTA_SYNC_STAGES < 2 || INTA_SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("INTA_SYNC_STAGES must be in the range 2-4");
    end

    typedef enum logic [1:0] {
        StIdle,
        StAck1,
        StAck2
    } state_e;

    state_e state_q, state_d;

    logic [INTA_SYNC_STAGES-1:0] inta_sync_q;
    logic                        inta_prev_q;
    logic                        inta_fall;

    logic       int_q, int_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] isr_set, isr_clr;
    logic [2:0] hp_q, hp_d;
    logic       cp_q, cp_d;
    logic       sp_q, sp_d;
    logic [2:0] low_pri_q, low_pri_d;

    logic [7:0] cand;
    logic [7:0] is_mask;
    logic       req_any, is_any;
    logic [2:0] req_lvl, is_lvl;
    logic       ack_take;

    // Rank 0 is the highest priority; the level just above lowPri gets rank 0.
    function automatic logic [2:0] rank_of(input logic [2:0] lvl, input logic [2:0] low);
        return lvl - low - 3'd1;
    endfunction

    // INTA is asynchronous; idle-high flops make reset look like INTA released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inta_sync_q <= '1;
            inta_prev_q <= 1'b1;
        end else begin
            inta_sync_q <= {inta_sync_q[INTA_SYNC_STAGES-2:0], INTA};
            inta_prev_q <= inta_sync_q[INTA_SYNC_STAGES-1];
        end
    end

    assign inta_fall = inta_prev_q & ~inta_sync_q[INTA_SYNC_STAGES-1];

    assign cand = irr & ~imr;

`ifdef SPECIAL_MASK_EN
    assign is_mask = smm ? (isr_q & ~imr) : isr_q;
`else
    assign is_mask = isr_q;
    logic unused_smm;
    assign unused_smm = smm;
`endif

    // Scan from the lowest priority upward so the highest-priority hit is written last.
    always_comb begin
        logic [2:0] lvl;
        req_any = 1'b0;
        req_lvl = 3'd0;
        is_any  = 1'b0;
        is_lvl  = 3'd0;
        lvl     = 3'd0;
        for (int r = 7; r >= 0; r--) begin
            lvl = low_pri_q + 3'd1 + 3'(r);
            if (cand[lvl]) begin
                req_any = 1'b1;
                req_lvl = lvl;
            end
            if (is_mask[lvl]) begin
                is_any = 1'b1;
                is_lvl = lvl;
            end
        end
    end

    // A first INTA is taken if a request is pending or INT was already raised.
    assign ack_take = inta_fall & (int_q | req_any);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (ack_take) state_d = StAck1;
            StAck1: if (inta_fall) state_d = StAck2;
            StAck2: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        int_d     = 1'b0;
        isr_set   = 8'h00;
        isr_clr   = 8'h00;
        hp_d      = hp_q;
        cp_d      = cp_q;
        sp_d      = sp_q;
        low_pri_d = low_pri_q;

        unique case (state_q)
            StIdle: begin
                if (ack_take) begin
                    cp_d = 1'b1;
                    if (req_any) begin
                        isr_set[req_lvl] = 1'b1;
                        hp_d             = req_lvl;
                        sp_d             = 1'b0;
                    end else begin
                        hp_d = 3'd7;
                        sp_d = 1'b1;
                    end
                end else begin
                    int_d = req_any &
                            (!is_any || (rank_of(req_lvl, low_pri_q) < rank_of(is_lvl, low_pri_q)));
                end
            end
            StAck1: begin
                if (inta_fall) cp_d = 1'b0;
            end
            StAck2: begin
                if (AEOI && !sp_q) begin
                    isr_clr[hp_q] = 1'b1;
                    if (eoiRotate) low_pri_d = hp_q;
                end
            end
            default: ;
        endcase

        // An explicit EOI command takes precedence over an automatic rotate.
        if (eoiValid) begin
            if (eoiSpecific) begin
                isr_clr[eoiLevel] = 1'b1;
                if (eoiRotate) low_pri_d = eoiLevel;
            end else if (is_any) begin
                isr_clr[is_lvl] = 1'b1;
                if (eoiRotate) low_pri_d = is_lvl;
            end
        end

        // Clear first, then set: an acknowledge beats an EOI on the same bit.
        isr_d = (isr_q & ~isr_clr) | isr_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_q     <= 1'b0;
            isr_q     <= 8'h00;
            hp_q      <= 3'd0;
            cp_q      <= 1'b0;
            sp_q      <= 1'b0;
            low_pri_q <= 3'd7;
        end else begin
            int_q     <= int_d;
            isr_q     <= isr_d;
            hp_q      <= hp_d;
            cp_q      <= cp_d;
            sp_q      <= sp_d;
            low_pri_q <= low_pri_d;
        end
    end

    assign INT             = int_q;
    assign isr             = isr_q;
    assign highestPriority = hp_q;
    assign currentPulse    = cp_q;
    assign spurious        = sp_q;

endmodule

// File: tb/tb_inservice_resolver.sv
// Directed self-checking bench for inservice_resolver.
// Build with SPECIAL_MASK_EN defined to exercise the special mask mode expectation.
module tb_inservice_resolver;

    logic       clk;
    logic       reset;
    logic [7:0] irr;
    logic [7:0] imr;
    logic       INTA;
    logic       AEOI;
    logic       eoiValid;
    logic       eoiSpecific;
    logic       eoiRotate;
    logic [2:0] eoiLevel;
    logic       smm;
    logic       INT;
    logic [7:0] isr;
    logic [2:0] highestPriority;
    logic       currentPulse;
    logic       spurious;

    int checks = 0;
    int errors = 0;

    inservice_resolver dut (
        .clk            (clk),
        .reset          (reset),
        .irr            (irr),
        .imr            (imr),
        .INTA           (INTA),
        .AEOI           (AEOI),
        .eoiValid       (eoiValid),
        .eoiSpecific    (eoiSpecific),
        .eoiRotate      (eoiRotate),
        .eoiLevel       (eoiLevel),
        .smm            (smm),
        .INT            (INT),
        .isr            (isr),
        .highestPriority(highestPriority),
        .currentPulse   (currentPulse),
        .spurious       (spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    // Long enough for the two-stage synchronizer plus edge detect to act.
    task automatic inta_pulse();
        INTA = 1'b0;
        step(4);
        INTA = 1'b1;
        step(4);
    endtask

    initial begin
        reset       = 1'b1;
        irr         = 8'h00;
        imr         = 8'h00;
        INTA        = 1'b1;
        AEOI        = 1'b0;
        eoiValid    = 1'b0;
        eoiSpecific = 1'b0;
        eoiRotate   = 1'b0;
        eoiLevel    = 3'd0;
        smm         = 1'b0;

        #12;
        check("rst_int", {7'd0, INT}, 8'h00);
        check("rst_isr", isr, 8'h00);
        check("rst_hp", {5'd0, highestPriority}, 8'h00);
        check("rst_cp", {7'd0, currentPulse}, 8'h00);
        check("rst_sp", {7'd0, spurious}, 8'h00);
        step(1);
        reset = 1'b0;
        step(1);

        // Basic acknowledge of the highest pending level.
        irr = 8'h05;
        step(1);
        check("t1_int", {7'd0, INT}, 8'h01);
        inta_pulse();
        check("t1_cp_mid", {7'd0, currentPulse}, 8'h01);
        check("t1_isr_mid", isr, 8'h01);
        check("t1_hp", {5'd0, highestPriority}, 8'h00);
        check("t1_int_mid", {7'd0, INT}, 8'h00);
        inta_pulse();
        check("t1_cp_end", {7'd0, currentPulse}, 8'h00);
        check("t1_isr_end", isr, 8'h01);
        check("t1_int_end", {7'd0, INT}, 8'h00);

        // Nesting: only a higher-priority request interrupts the level in service.
        apply_reset();
        irr = 8'h04;
        inta_pulse();
        inta_pulse();
        check("t2_isr4", isr, 8'h04);
        irr = 8'h08;
        step(2);
        check("t2_int_low", {7'd0, INT}, 8'h00);
        irr = 8'h02;
        step(2);
        check("t2_int_high", {7'd0, INT}, 8'h01);
        inta_pulse();
        inta_pulse();
        check("t2_isr6", isr, 8'h06);
        check("t2_hp", {5'd0, highestPriority}, 8'h01);

        // Auto-EOI with rotation moves the lowest priority to level 4.
        apply_reset();
        AEOI      = 1'b1;
        eoiRotate = 1'b1;
        irr       = 8'h10;
        step(1);
        check("t3_int", {7'd0, INT}, 8'h01);
        inta_pulse();
        check("t3_hp4", {5'd0, highestPriority}, 8'h04);
        check("t3_isr_mid", isr, 8'h10);
        inta_pulse();
        check("t3_isr_aeoi", isr, 8'h00);
        irr = 8'h21;
        step(1);
        inta_pulse();
        check("t3_hp5", {5'd0, highestPriority}, 8'h05);
        check("t3_isr20", isr, 8'h20);
        inta_pulse();
        check("t3_isr_aeoi2", isr, 8'h00);
        AEOI      = 1'b0;
        eoiRotate = 1'b0;
        irr       = 8'h00;

        // Spurious: request withdrawn after INT was raised but before the ack lands.
        apply_reset();
        irr = 8'h02;
        inta_pulse();
        inta_pulse();
        irr = 8'h01;
        step(1);
        check("t4_int", {7'd0, INT}, 8'h01);
        INTA = 1'b0;
        step(2);
        irr = 8'h00;
        step(1);
        check("t4_hp7", {5'd0, highestPriority}, 8'h07);
        check("t4_sp", {7'd0, spurious}, 8'h01);
        check("t4_isr", isr, 8'h02);
        check("t4_cp", {7'd0, currentPulse}, 8'h01);
        step(1);
        INTA = 1'b1;
        step(4);
        inta_pulse();
        check("t4_sp_hold", {7'd0, spurious}, 8'h01);
        check("t4_cp_end", {7'd0, currentPulse}, 8'h00);
        irr = 8'h01;
        step(1);
        inta_pulse();
        check("t4_sp_clr", {7'd0, spurious}, 8'h00);
        check("t4_hp0", {5'd0, highestPriority}, 8'h00);
        check("t4_isr3", isr, 8'h03);
        inta_pulse();
        irr = 8'h00;

        // Explicit EOI commands.
        apply_reset();
        irr = 8'h08;
        inta_pulse();
        inta_pulse();
        irr = 8'h02;
        step(1);
        inta_pulse();
        inta_pulse();
        check("t5_isr0a", isr, 8'h0a);
        irr         = 8'h00;
        eoiValid    = 1'b1;
        eoiSpecific = 1'b0;
        step(1);
        eoiValid = 1'b0;
        check("t5_nseoi", isr, 8'h08);
        eoiValid    = 1'b1;
        eoiSpecific = 1'b1;
        eoiLevel    = 3'd3;
        step(1);
        eoiValid = 1'b0;
        check("t5_seoi", isr, 8'h00);
        eoiSpecific = 1'b0;
        eoiValid    = 1'b1;
        step(1);
        eoiValid = 1'b0;
        check("t5_nseoi_empty", isr, 8'h00);

        // EOI clearing the very bit being set in the same cycle: the set wins.
        apply_reset();
        irr = 8'h01;
        step(1);
        INTA = 1'b0;
        step(2);
        eoiValid    = 1'b1;
        eoiSpecific = 1'b1;
        eoiLevel    = 3'd0;
        step(1);
        eoiValid    = 1'b0;
        eoiSpecific = 1'b0;
        check("t6_set_wins", isr, 8'h01);
        step(1);
        INTA = 1'b1;
        step(4);
        inta_pulse();
        irr = 8'h00;

        // Asynchronous reset in ACK1, then a clean restart.
        apply_reset();
        irr = 8'h04;
        step(1);
        inta_pulse();
        check("t7_pre_hp", {5'd0, highestPriority}, 8'h02);
        #2;
        reset = 1'b1;
        #1;
        check("t7_async_isr", isr, 8'h00);
        check("t7_async_hp", {5'd0, highestPriority}, 8'h00);
        check("t7_async_cp", {7'd0, currentPulse}, 8'h00);
        check("t7_async_int", {7'd0, INT}, 8'h00);
        check("t7_async_sp", {7'd0, spurious}, 8'h00);
        irr = 8'h01;
        step(2);
        reset = 1'b0;
        step(2);
        check("t7_int_after", {7'd0, INT}, 8'h01);
        check("t7_cp_after", {7'd0, currentPulse}, 8'h00);
        inta_pulse();
        check("t7_first_cp", {7'd0, currentPulse}, 8'h01);
        check("t7_first_isr", isr, 8'h01);
        inta_pulse();
        irr = 8'h00;

        // Special mask mode hides level 0 from the in-service scan when enabled.
        apply_reset();
        irr = 8'h01;
        inta_pulse();
        inta_pulse();
        irr = 8'h00;
        imr = 8'h01;
        smm = 1'b1;
        irr = 8'h04;
        step(2);
`ifdef SPECIAL_MASK_EN
        check("t8_smm_int", {7'd0, INT}, 8'h01);
`else
        check("t8_smm_int", {7'd0, INT}, 8'h00);
`endif
        smm = 1'b0;
        step(2);
        check("t8_nosmm_int", {7'd0, INT}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
